// File: rtl/arbiter_pkg.sv
// Shared types for the line-granular memory arbiter.
// State and operation encodings used by the top and its bench.
package arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_DONE
    } arb_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } arb_op_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Picks one requester, starting at ptr when rr_en is set, else at index 0.
// Also flags when more than one requester is active.
module rr_priority_picker #(
    parameter int N = 2,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          rr_en,
    output logic [PW-1:0] winner,
    output logic          valid,
    output logic          multi
);

    int idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        multi  = 1'b0;
        idx    = 0;
        for (int i = 0; i < N; i++) begin
            idx = rr_en ? int'(ptr) + i : i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                if (valid) begin
                    multi = 1'b1;
                end else begin
                    winner = PW'(idx);
                    valid  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// N-port line arbiter: one transaction in flight, request latched at grant,
// response routed back to the granted port only.
import arbiter_pkg::*;

module mem_arbiter_rr #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256,
    parameter bit RR_MODE    = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            req_read,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]            req_resp,
    output logic [LINE_WIDTH-1:0]           req_rdata,
    output logic                            mem_read,
    output logic                            mem_write,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [LINE_WIDTH-1:0]           mem_wdata,
    input  logic                            mem_resp,
    input  logic [LINE_WIDTH-1:0]           mem_rdata,
    output logic                            perf_conflict
);

    localparam int PW = $clog2(NUM_PORTS);

    arb_state_t state;
    arb_state_t state_next;
    arb_op_t    op;

    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        grant;
    logic [PW-1:0]        winner;
    logic [NUM_PORTS-1:0] req_vec;
    logic                 valid;
    logic                 multi;
    logic                 grant_now;
    logic                 done_now;

    assign req_vec   = req_read | req_write;
    assign grant_now = (state == ARB_IDLE) && valid;
    assign done_now  = (state == ARB_BUSY) && mem_resp;

    rr_priority_picker #(
        .N(NUM_PORTS)
    ) u_picker (
        .req    (req_vec),
        .ptr    (rr_ptr),
        .rr_en  (RR_MODE),
        .winner (winner),
        .valid  (valid),
        .multi  (multi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ARB_IDLE: if (valid) state_next = ARB_BUSY;
            ARB_BUSY: if (mem_resp) state_next = ARB_DONE;
            ARB_DONE: state_next = ARB_IDLE;
            default:  state_next = ARB_IDLE;
        endcase
    end

    // A simultaneous read+write on one port resolves to the write.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant     <= '0;
            op        <= OP_READ;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rr_ptr    <= '0;
        end else begin
            if (grant_now) begin
                grant     <= winner;
                op        <= req_write[winner] ? OP_WRITE : OP_READ;
                mem_addr  <= req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata <= req_wdata[int'(winner)*LINE_WIDTH +: LINE_WIDTH];
            end
            if (done_now && RR_MODE) begin
                if (grant == PW'(NUM_PORTS - 1)) begin
                    rr_ptr <= '0;
                end else begin
                    rr_ptr <= grant + 1'b1;
                end
            end
        end
    end

    assign mem_read  = (state == ARB_BUSY) && (op == OP_READ);
    assign mem_write = (state == ARB_BUSY) && (op == OP_WRITE);
    assign req_rdata = mem_rdata;

    always_comb begin
        req_resp = '0;
        if (done_now) begin
            req_resp[grant] = 1'b1;
        end
    end

    assign perf_conflict = !rst && grant_now && multi;

    a_no_rw: assert property (
        @(posedge clk) disable iff (rst) (req_read & req_write) == '0
    ) else $error("read and write requested together on one port");

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench: a round-robin and a fixed-priority arbiter
// driven in lockstep with the same stimulus.
module tb_mem_arbiter_rr;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_read;
    logic [3:0]    req_write;
    logic [127:0]  req_addr;
    logic [1023:0] req_wdata;
    logic          mem_resp;
    logic [255:0]  mem_rdata;

    logic [3:0]   a_req_resp;
    logic [255:0] a_req_rdata;
    logic         a_mem_read;
    logic         a_mem_write;
    logic [31:0]  a_mem_addr;
    logic [255:0] a_mem_wdata;
    logic         a_perf;

    logic [3:0]   b_req_resp;
    logic [255:0] b_req_rdata;
    logic         b_mem_read;
    logic         b_mem_write;
    logic [31:0]  b_mem_addr;
    logic [255:0] b_mem_wdata;
    logic         b_perf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_rr #(
        .NUM_PORTS(4), .ADDR_WIDTH(32), .LINE_WIDTH(256), .RR_MODE(1'b1)
    ) u_rr (
        .clk           (clk),
        .rst           (rst),
        .req_read      (req_read),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_resp      (a_req_resp),
        .req_rdata     (a_req_rdata),
        .mem_read      (a_mem_read),
        .mem_write     (a_mem_write),
        .mem_addr      (a_mem_addr),
        .mem_wdata     (a_mem_wdata),
        .mem_resp      (mem_resp),
        .mem_rdata     (mem_rdata),
        .perf_conflict (a_perf)
    );

    mem_arbiter_rr #(
        .NUM_PORTS(4), .ADDR_WIDTH(32), .LINE_WIDTH(256), .RR_MODE(1'b0)
    ) u_fp (
        .clk           (clk),
        .rst           (rst),
        .req_read      (req_read),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_resp      (b_req_resp),
        .req_rdata     (b_req_rdata),
        .mem_read      (b_mem_read),
        .mem_write     (b_mem_write),
        .mem_addr      (b_mem_addr),
        .mem_wdata     (b_mem_wdata),
        .mem_resp      (mem_resp),
        .mem_rdata     (mem_rdata),
        .perf_conflict (b_perf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered in IDLE; runs one transaction with a 2-cycle memory latency.
    task automatic serve(input int pa, input int pb, input logic conf,
                         input logic [255:0] rd);
        logic       wa;
        logic       wb;
        logic [3:0] ea;
        logic [3:0] eb;
        #1;
        wa = req_write[pa];
        wb = req_write[pb];
        ea = 4'b0001 << pa;
        eb = 4'b0001 << pb;
        chk("rr_conflict", a_perf, conf);
        chk("fp_conflict", b_perf, conf);
        step();
        chk("rr_mem_read", a_mem_read, !wa);
        chk("rr_mem_write", a_mem_write, wa);
        chk("rr_mem_addr", a_mem_addr, req_addr[pa*32 +: 32]);
        chk("rr_mem_wdata", a_mem_wdata, req_wdata[pa*256 +: 256]);
        chk("rr_resp_busy", a_req_resp, 4'b0000);
        chk("fp_mem_read", b_mem_read, !wb);
        chk("fp_mem_write", b_mem_write, wb);
        chk("fp_mem_addr", b_mem_addr, req_addr[pb*32 +: 32]);
        chk("fp_mem_wdata", b_mem_wdata, req_wdata[pb*256 +: 256]);
        chk("fp_resp_busy", b_req_resp, 4'b0000);
        step();
        mem_resp  = 1'b1;
        mem_rdata = rd;
        #1;
        chk("rr_req_resp", a_req_resp, ea);
        chk("rr_req_rdata", a_req_rdata, rd);
        chk("fp_req_resp", b_req_resp, eb);
        chk("fp_req_rdata", b_req_rdata, rd);
        step();
        mem_resp  = 1'b0;
        mem_rdata = '0;
        #1;
        chk("rr_done_read", a_mem_read, 1'b0);
        chk("rr_done_write", a_mem_write, 1'b0);
        chk("rr_done_resp", a_req_resp, 4'b0000);
        chk("fp_done_read", b_mem_read, 1'b0);
        chk("fp_done_write", b_mem_write, 1'b0);
        chk("fp_done_resp", b_req_resp, 4'b0000);
        step();
    endtask

    initial begin
        rst       = 1'b1;
        req_read  = 4'hF;
        req_write = 4'h0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*32 +: 32]    = 32'h100 * (i + 1);
            req_wdata[i*256 +: 256] = {8{32'h1111_1111 * (i + 1)}};
        end

        // Reset held with every port requesting
        step();
        step();
        chk("rst_rr_read", a_mem_read, 1'b0);
        chk("rst_rr_write", a_mem_write, 1'b0);
        chk("rst_rr_resp", a_req_resp, 4'b0000);
        chk("rst_rr_addr", a_mem_addr, 32'h0);
        chk("rst_rr_perf", a_perf, 1'b0);
        chk("rst_fp_read", b_mem_read, 1'b0);
        chk("rst_fp_resp", b_req_resp, 4'b0000);
        rst = 1'b0;

        // All four reading: RR walks 0,1,2,3,0; fixed priority stays on 0
        serve(0, 0, 1'b1, {8{32'h0000_0A00}});
        serve(1, 0, 1'b1, {8{32'h0000_0A01}});
        serve(2, 0, 1'b1, {8{32'h0000_0A02}});
        serve(3, 0, 1'b1, {8{32'h0000_0A03}});
        serve(0, 0, 1'b1, {8{32'h0000_0A04}});

        // Ports 1 and 3: fixed priority keeps serving 1 until it drops
        req_read = 4'b1010;
        serve(1, 1, 1'b1, {8{32'h0000_0B01}});
        serve(3, 1, 1'b1, {8{32'h0000_0B02}});
        req_read = 4'b1000;
        serve(3, 3, 1'b0, {8{32'h0000_0B03}});

        // Port 2 line write
        req_read                = 4'b0000;
        req_write               = 4'b0100;
        req_addr[64 +: 32]      = 32'h0000_1000;
        req_wdata[512 +: 256]   = {32{8'hA5}};
        serve(2, 2, 1'b0, '0);

        // Port 1 read of a recognisable line
        req_write = 4'b0000;
        req_read  = 4'b0010;
        serve(1, 1, 1'b0, {8{32'hDEAD_BEEF}});

        // Reset while busy; spurious mem_resp afterwards
        req_read = 4'b1000;
        step();
        chk("busy_rr_read", a_mem_read, 1'b1);
        chk("busy_fp_read", b_mem_read, 1'b1);
        chk("busy_rr_addr", a_mem_addr, 32'h400);
        rst      = 1'b1;
        req_read = 4'b0000;
        step();
        rst      = 1'b0;
        mem_resp = 1'b1;
        #1;
        chk("mid_rr_read", a_mem_read, 1'b0);
        chk("mid_rr_addr", a_mem_addr, 32'h0);
        chk("mid_rr_wdata", a_mem_wdata, 256'h0);
        chk("mid_rr_resp", a_req_resp, 4'b0000);
        chk("mid_fp_read", b_mem_read, 1'b0);
        chk("mid_fp_resp", b_req_resp, 4'b0000);
        step();
        chk("spur_rr_read", a_mem_read, 1'b0);
        chk("spur_rr_resp", a_req_resp, 4'b0000);
        chk("spur_fp_read", b_mem_read, 1'b0);
        mem_resp = 1'b0;

        // Pointer back at 0 after reset: port 1 wins over port 3
        req_read = 4'b1010;
        serve(1, 1, 1'b1, {8{32'h0000_0C01}});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
